md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have port start, input, 1 bit: launches the operation selected by op when high.
REQ-004 The block SHALL have port op, input, 2 bits: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have port A, input, 32 bits: first operand (rs value from GRF RD1); the dividend for divides.
REQ-006 The block SHALL have port B, input, 32 bits: second operand (rt value from GRF RD2); the divisor for divides.
REQ-007 The block SHALL have port hilo_we, input, 1 bit: direct write enable for MTHI/MTLO.
REQ-008 The block SHALL have port hilo_sel, input, 1 bit: direct write target; 1 = HI, 0 = LO.
REQ-009 The block SHALL have port WD, input, 32 bits: direct write data.
REQ-010 The block SHALL have port busy, output, 1 bit: registered; high while an operation is in flight.
REQ-011 The block SHALL have ports HI and LO, outputs, 32 bits each: registered result registers (source for MFHI/MFLO writeback into the GRF).

Function
REQ-012 States SHALL be IDLE, MUL, DIV and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 start SHALL be accepted only in IDLE; on the accepting edge the block SHALL latch A, B and op and enter MUL (op 00/01) or DIV (op 10/11).
REQ-014 start while busy SHALL be ignored, with no effect on state, operands or results.
REQ-015 MUL SHALL last 5 cycles under a 3-bit counter; on the edge ending cycle 5, {HI,LO} SHALL take the 64-bit product, signed for MULT and unsigned for MULTU, and the state SHALL return to IDLE.
REQ-016 DIV SHALL run 32 restoring-division iterations on operand magnitudes, one quotient bit per cycle, MSB first; signed ops SHALL use two's-complement magnitudes, and unsigned ops SHALL use the raw operands.
REQ-017 After the 32nd iteration the state SHALL be FIX for 1 cycle; at its end LO SHALL take the quotient and HI the remainder, and the state SHALL return to IDLE.
REQ-018 Total busy duration SHALL be 5 cycles for multiplies and 33 cycles for divides, with no early termination.
REQ-019 For DIV, the quotient SHALL be negated if A and B signs differ, and the remainder SHALL take the sign of A (truncating division).
REQ-020 0x80000000 / 0xFFFFFFFF for DIV SHALL give LO = 0x80000000 and HI = 0.
REQ-021 Division by zero, signed or unsigned, SHALL give LO = 0xFFFFFFFF and HI = the original A, and SHALL still take 33 cycles.
REQ-022 hilo_we SHALL update HI (hilo_sel = 1) or LO (hilo_sel = 0) with WD on the edge, only in IDLE; hilo_we while busy SHALL be ignored.
REQ-023 If start and hilo_we are both high in IDLE, both SHALL take effect; the direct write SHALL land immediately, and the operation result SHALL later overwrite both HI and LO.
REQ-024 HI and LO SHALL change only at the completion edge (REQ-015, REQ-017) or on a direct write (REQ-022), and SHALL hold their values otherwise, including throughout busy.
REQ-025 Intermediate divider state SHALL NOT be visible on HI or LO.

Reset
REQ-026 While reset = 0, asynchronously and regardless of clk: state SHALL be IDLE, busy = 0, HI = 0, LO = 0, and the counter, latched operands and divider registers SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL abort it with no partial result written; after release the block SHALL accept start on the first clk edge.

Verification
REQ-028 MULT with A = 0xFFFFFFFE (-2), B = 3: busy high for exactly 5 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFFA; MULTU with the same operands: HI = 0x00000002, LO = 0xFFFFFFFA.
REQ-029 DIV with A = 0xFFFFFFF9 (-7), B = 2: busy high for 33 cycles, then LO = 0xFFFFFFFD and HI = 0xFFFFFFFF; DIVU with A = 7, B = 2: LO = 3, HI = 1.
REQ-030 DIVU with A = 0x12345678, B = 0: LO = 0xFFFFFFFF and HI = 0x12345678 after 33 cycles; DIV with A = 0x80000000, B = 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-031 start with op = DIV, then start and hilo_we pulsed at cycle 10: both ignored, and the final HI/LO equal the original division's result.
REQ-032 hilo_we = 1, hilo_sel = 1, WD = 0xDEADBEEF in IDLE: HI = 0xDEADBEEF on the next edge with LO unchanged; the same stimulus with hilo_sel = 0 updates LO only.
REQ-033 reset driven low at cycle 20 of a DIV: busy, HI and LO go to 0 immediately, without a clk edge; after release, a new MULTU with A = 3, B = 4 completes in 5 cycles with LO = 12.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
// Multiplies take 5 busy cycles, divides 32 restoring iterations plus one sign-fix cycle.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] WD,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  state_t      state;
  logic [2:0]  mul_cnt;
  logic [4:0]  div_cnt;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q, dmag_q;

  logic [31:0] a_mag, b_mag;
  logic [63:0] a_ext, b_ext, product;
  logic [32:0] shifted;
  logic        take;
  logic [31:0] rem_next, quo_next;
  logic        neg_q, neg_r;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    a_mag = ((op == OP_DIV) && A[31]) ? -A : A;
    b_mag = ((op == OP_DIV) && B[31]) ? -B : B;

    // Sign-extending into 64 bits makes the truncated unsigned product equal the signed one.
    a_ext   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product = a_ext * b_ext;

    shifted  = {rem_q, quo_q[31]};
    take     = shifted[32] || (shifted[31:0] >= dmag_q);
    rem_next = take ? (shifted[31:0] - dmag_q) : shifted[31:0];
    quo_next = {quo_q[30:0], take};

    neg_q = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
    neg_r = (op_q == OP_DIV) && a_q[31];
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      mul_cnt <= 3'd0;
      div_cnt <= 5'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dmag_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hilo_we) begin
            if (hilo_sel) HI <= WD;
            else          LO <= WD;
          end
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            busy    <= 1'b1;
            mul_cnt <= 3'd0;
            div_cnt <= 5'd0;
            if (op[1]) begin
              state  <= S_DIV;
              rem_q  <= 32'd0;
              quo_q  <= a_mag;
              dmag_q <= b_mag;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == 3'd4) begin
            {HI, LO} <= product;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt + 3'd1;
          end
        end
        S_DIV: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          // Zero divisor bypasses the sign fix: all-ones quotient, untouched dividend as remainder.
          if (b_q == 32'd0) begin
            LO <= 32'hFFFF_FFFF;
            HI <= a_q;
          end else begin
            LO <= q_fix;
            HI <= r_fix;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] WD = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_pass = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .WD(WD),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called just after a negedge with the unit idle; returns at a negedge with it idle again.
  // poke_at >= 0 pulses start and a LO write during that busy cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int poke_at, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo);
    int n;
    logic held;
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    n = 0;
    held = 1'b1;
    while (busy && n < 100) begin
      if (HI !== prev_hi || LO !== prev_lo) held = 1'b0;
      if (n == poke_at) begin
        start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd5;
        hilo_we = 1'b1; hilo_sel = 1'b0; WD = 32'hAAAA_5555;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; hilo_we = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, " hold"}, {31'd0, held}, 32'd1);
    check({tag, " HI"}, HI, exp_hi);
    check({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    int n;
    #2 reset = 1'b0;
    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult -2*3",   2'b00, 32'hFFFF_FFFE, 32'd3, -1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0, 32'd0);
    run_op("multu fffffffe*3", 2'b01, 32'hFFFF_FFFE, 32'd3, -1, 5, 32'h0000_0002, 32'hFFFF_FFFA,
           32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, -1, 5, 32'h4000_0000, 32'd0,
           32'h0000_0002, 32'hFFFF_FFFA);

    run_op("div -7/2",  2'b10, 32'hFFFF_FFF9, 32'd2, -1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'h4000_0000, 32'd0);
    run_op("divu 7/2",  2'b11, 32'd7, 32'd2, -1, 33, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2",  2'b10, 32'd7, 32'hFFFF_FFFE, -1, 33, 32'd1, 32'hFFFF_FFFD, 32'd1, 32'd3);
    run_op("div -7/-2", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, -1, 33, 32'hFFFF_FFFF, 32'd3,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu max/16", 2'b11, 32'hFFFF_FFFF, 32'h10, -1, 33, 32'hF, 32'h0FFF_FFFF,
           32'hFFFF_FFFF, 32'd3);
    run_op("divu by 0", 2'b11, 32'h1234_5678, 32'd0, -1, 33, 32'h1234_5678, 32'hFFFF_FFFF,
           32'hF, 32'h0FFF_FFFF);
    run_op("div -5 by 0", 2'b10, 32'hFFFF_FFFB, 32'd0, -1, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
           32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 33, 32'd0, 32'h8000_0000,
           32'hFFFF_FFFB, 32'hFFFF_FFFF);

    hilo_we = 1'b1; hilo_sel = 1'b1; WD = 32'hDEAD_BEEF;
    @(negedge clk);
    hilo_we = 1'b0;
    check("mthi HI", HI, 32'hDEAD_BEEF);
    check("mthi LO", LO, 32'h8000_0000);
    hilo_we = 1'b1; hilo_sel = 1'b0; WD = 32'hCAFE_F00D;
    @(negedge clk);
    hilo_we = 1'b0;
    check("mtlo HI", HI, 32'hDEAD_BEEF);
    check("mtlo LO", LO, 32'hCAFE_F00D);
    check("mtlo busy", {31'd0, busy}, 32'd0);

    op = 2'b01; A = 32'd3; B = 32'd4; start = 1'b1;
    hilo_we = 1'b1; hilo_sel = 1'b1; WD = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    check("start+mthi HI", HI, 32'h1111_1111);
    check("start+mthi LO", LO, 32'hCAFE_F00D);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("start+mthi cycles", 32'(n), 32'd5);
    check("start+mthi final HI", HI, 32'd0);
    check("start+mthi final LO", LO, 32'd12);

    run_op("divu 100/7 poked", 2'b11, 32'd100, 32'd7, 10, 33, 32'd2, 32'd14, 32'd0, 32'd12);

    op = 2'b10; A = 32'hFFFF_FFF9; B = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("mid div busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset HI", HI, 32'd0);
    check("async reset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("multu 3*4 after reset", 2'b01, 32'd3, 32'd4, -1, 5, 32'd0, 32'd12, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
